// File: rtl/serial_bit_source.sv
// serial_bit_source
// Parallel-in/serial-out bit source feeding the 1-bit input of the "101"
// sequence detector. WIDTH-bit words arrive over a valid/ready handshake and
// leave one bit per enabled clock on a. A one-entry holding register lets
// consecutive words stream out with no idle cycle between them.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (0 = reset)
//   din        parallel word
//   din_valid  din holds a word to transfer
//   din_ready  block can take a word this cycle (= hold register empty)
//   en         shift enable; 0 freezes the serializer
//   a          serial bit to the detector (IDLE_LEVEL when a_valid=0)
//   a_valid    a carries a data bit this cycle
//   a_last     a carries the final bit of a word
//   busy       shifter or holding register occupied
module serial_bit_source #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             a,
    output logic             a_valid,
    output logic             a_last,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shift_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] hold_r;
    logic             hold_full_r;

    logic             accept_s;
    logic [WIDTH-1:0] shift_next_s;

    // Bit that goes out first from a word sitting in the shifter.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Shifter contents after the current head bit has been sent.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready only depends on the hold register, never on en or din_valid.
    assign din_ready    = !hold_full_r;
    assign accept_s     = din_valid && !hold_full_r;
    assign shift_next_s = advance(shift_r);

    // Serializer FSM: shifter, bit counter, holding register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            shift_r     <= '0;
            cnt_r       <= '0;
            hold_r      <= '0;
            hold_full_r <= 1'b0;
            a           <= IDLE_LEVEL;
            a_valid     <= 1'b0;
            a_last      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Direct load ignores en: the first bit appears right after the accept edge.
                    if (accept_s) begin
                        state_r <= ST_SHIFT;
                        shift_r <= din;
                        cnt_r   <= '0;
                        a       <= head(din);
                        a_valid <= 1'b1;
                        a_last  <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        a       <= IDLE_LEVEL;
                        a_valid <= 1'b0;
                        a_last  <= 1'b0;
                        busy    <= hold_full_r;
                    end
                end
                ST_SHIFT: begin
                    if (en) begin
                        if (cnt_r == LAST_IDX) begin
                            // Last bit done: refill from hold first, else from din, else go idle.
                            // din_ready=0 whenever hold is full, so no accept collides with the refill.
                            if (hold_full_r) begin
                                shift_r     <= hold_r;
                                hold_full_r <= 1'b0;
                                cnt_r       <= '0;
                                a           <= head(hold_r);
                                a_valid     <= 1'b1;
                                a_last      <= 1'b0;
                                busy        <= 1'b1;
                            end else if (accept_s) begin
                                shift_r <= din;
                                cnt_r   <= '0;
                                a       <= head(din);
                                a_valid <= 1'b1;
                                a_last  <= 1'b0;
                                busy    <= 1'b1;
                            end else begin
                                state_r <= ST_IDLE;
                                cnt_r   <= '0;
                                a       <= IDLE_LEVEL;
                                a_valid <= 1'b0;
                                a_last  <= 1'b0;
                                busy    <= 1'b0;
                            end
                        end else begin
                            shift_r <= shift_next_s;
                            cnt_r   <= cnt_r + CW'(1);
                            a       <= head(shift_next_s);
                            a_valid <= 1'b1;
                            a_last  <= (cnt_r == (LAST_IDX - CW'(1)));
                            busy    <= 1'b1;
                            if (accept_s) begin
                                hold_r      <= din;
                                hold_full_r <= 1'b1;
                            end else begin
                                hold_full_r <= hold_full_r;
                            end
                        end
                    end else begin
                        // Stall: outputs and count frozen, hold may still be filled.
                        busy <= 1'b1;
                        if (accept_s) begin
                            hold_r      <= din;
                            hold_full_r <= 1'b1;
                        end else begin
                            hold_full_r <= hold_full_r;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= '0;
                    hold_full_r <= 1'b0;
                    a           <= IDLE_LEVEL;
                    a_valid     <= 1'b0;
                    a_last      <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bit_source.sv
// Self-checking bench for serial_bit_source. An MSB-first instance is checked
// against a scoreboard of expected {bit,last} pairs pushed when words are sent
// and popped by a monitor as bits are consumed; an LSB-first instance drives a
// small behavioural "101" detector.
module tb_serial_bit_source;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         en;
    logic         a;
    logic         a_valid;
    logic         a_last;
    logic         busy;

    logic [W-1:0] din2;
    logic         din_valid2;
    logic         din_ready2;
    logic         a2;
    logic         a_valid2;
    logic         a_last2;
    logic         busy2;

    int           checks    = 0;
    int           errors    = 0;
    logic [1:0]   sb_q[$];
    bit           mon_en    = 1'b0;
    int           valid_run = 0;
    int           last_run  = 0;

    always #5 clk = ~clk;

    serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .en(en), .a(a), .a_valid(a_valid), .a_last(a_last), .busy(busy)
    );

    serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din2), .din_valid(din_valid2), .din_ready(din_ready2),
        .en(en), .a(a2), .a_valid(a_valid2), .a_last(a_last2), .busy(busy2)
    );

    // Monitor: compare each presented bit with the scoreboard head; consume it when en=1.
    always @(negedge clk) begin
        logic [1:0] dummy;
        if (mon_en && rst) begin
            if (a_valid) begin
                valid_run = valid_run + 1;
                checks = checks + 1;
                if (sb_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_bit got a=%0b a_last=%0b, expected no data", a, a_last);
                end else if ({a, a_last} !== sb_q[0]) begin
                    errors = errors + 1;
                    $display("FAIL stream_bit got a=%0b a_last=%0b, expected a=%0b a_last=%0b",
                             a, a_last, sb_q[0][1], sb_q[0][0]);
                end
                if (en && sb_q.size() != 0) dummy = sb_q.pop_front();
            end else begin
                if (valid_run != 0) last_run = valid_run;
                valid_run = 0;
                checks = checks + 1;
                if ({a, a_last} !== 2'b00) begin
                    errors = errors + 1;
                    $display("FAIL idle_outputs got a=%0b a_last=%0b, expected 0 0", a, a_last);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a word on the MSB-first instance and wait for it to be accepted.
    // Called and returns at 1ns after a rising edge.
    task automatic send(input logic [W-1:0] w);
        int guard = 0;
        din       = w;
        din_valid = 1'b1;
        while (!din_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (!din_ready) begin
            errors++;
            $display("FAIL send_timeout word=%h din_ready=%0b, expected 1", w, din_ready);
            din_valid = 1'b0;
        end else begin
            for (int i = W - 1; i >= 0; i--) sb_q.push_back({w[i], 1'(i == 0)});
            @(posedge clk); #1;
            din_valid = 1'b0;
        end
    endtask

    // Wait until the scoreboard is empty and the output has gone idle.
    task automatic drain();
        int guard = 0;
        while ((sb_q.size() != 0 || a_valid) && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        checks++;
        if (sb_q.size() != 0 || a_valid) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d a_valid=%0b, expected 0 0", sb_q.size(), a_valid);
        end
        checks++;
        if (busy !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL drained_state got busy=%0b din_ready=%0b, expected 0 1", busy, din_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1;
        din = '0; din_valid = 1'b0; din2 = '0; din_valid2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a, a_valid, a_last, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL in_reset got a=%0b a_valid=%0b a_last=%0b busy=%0b, expected 0000", a, a_valid, a_last, busy);
        end
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({a, a_valid, din_ready, busy} !== 4'b0010) begin
                errors++;
                $display("FAIL idle_after_reset cycle %0d got a=%0b a_valid=%0b din_ready=%0b busy=%0b, expected 0 0 1 0",
                         i, a, a_valid, din_ready, busy);
            end
            checks++;
            if ({a2, a_valid2, din_ready2, busy2} !== 4'b0010) begin
                errors++;
                $display("FAIL idle_after_reset_lsb got a=%0b a_valid=%0b din_ready=%0b busy=%0b, expected 0 0 1 0",
                         a2, a_valid2, din_ready2, busy2);
            end
        end
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    task automatic test_single_word();
        last_run = 0;
        send(8'b1010_0101);
        // First bit must already be on a right after the accept edge.
        checks++;
        if ({a, a_valid} !== 2'b11) begin
            errors++;
            $display("FAIL first_bit_latency got a=%0b a_valid=%0b, expected 1 1", a, a_valid);
        end
        drain();
        checks++;
        if (last_run != 8) begin
            errors++;
            $display("FAIL single_run got %0d valid cycles, expected 8", last_run);
        end
    endtask

    task automatic test_back_to_back();
        // Second word lands in hold while the first is shifting.
        last_run = 0;
        send(8'hA5);
        send(8'h3C);
        checks++;
        if (din_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_full got din_ready=%0b busy=%0b, expected 0 1", din_ready, busy);
        end
        drain();
        checks++;
        if (last_run != 16) begin
            errors++;
            $display("FAIL hold_stream_run got %0d valid cycles, expected 16", last_run);
        end
        // Second word accepted exactly on the last-bit edge: direct reload, no gap.
        last_run = 0;
        send(8'hA5);
        repeat (7) @(posedge clk);
        #1;
        send(8'h66);
        drain();
        checks++;
        if (last_run != 16) begin
            errors++;
            $display("FAIL direct_reload_run got %0d valid cycles, expected 16", last_run);
        end
    endtask

    task automatic test_stall();
        last_run = 0;
        send(8'hF0);
        repeat (4) @(posedge clk);
        #1;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({a, a_valid, a_last} !== 3'b010) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got a=%0b a_valid=%0b a_last=%0b, expected 0 1 0",
                         i, a, a_valid, a_last);
            end
            @(posedge clk); #1;
        end
        en = 1'b1;
        drain();
        checks++;
        if (last_run != 11) begin
            errors++;
            $display("FAIL stall_run got %0d valid cycles, expected 11", last_run);
        end
    endtask

    task automatic test_reset_mid_word();
        send(8'hFF);
        send(8'h81);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || din_ready !== 1'b0 || a_valid !== 1'b1) begin
            errors++;
            $display("FAIL before_reset got busy=%0b din_ready=%0b a_valid=%0b, expected 1 0 1", busy, din_ready, a_valid);
        end
        #2;
        mon_en = 1'b0;
        valid_run = 0;
        rst = 1'b0;
        #1;
        checks++;
        if ({a, a_valid, a_last, busy, din_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL async_reset got a=%0b a_valid=%0b a_last=%0b busy=%0b din_ready=%0b, expected 0 0 0 0 1",
                     a, a_valid, a_last, busy, din_ready);
        end
        sb_q.delete();
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            checks++;
            if (a_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL after_reset cycle %0d got a_valid=%0b busy=%0b, expected 0 0", i, a_valid, busy);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lsb_detector();
        logic [W-1:0] w;
        logic [1:0]   exp_q[$];
        logic [1:0]   e;
        logic [2:0]   hist;
        int           nbits;
        int           y_count;
        w = 8'b0000_0101;
        hist = 3'b000; nbits = 0; y_count = 0;
        din2 = w;
        din_valid2 = 1'b1;
        checks++;
        if (din_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL lsb_ready got %0b, expected 1", din_ready2);
        end
        for (int i = 0; i < W; i++) exp_q.push_back({w[i], 1'(i == W - 1)});
        @(posedge clk); #1;
        din_valid2 = 1'b0;
        for (int i = 0; i < W; i++) begin
            e = exp_q.pop_front();
            checks++;
            if ({a_valid2, a2, a_last2} !== {1'b1, e}) begin
                errors++;
                $display("FAIL lsb_bit %0d got a_valid=%0b a=%0b a_last=%0b, expected 1 %0b %0b",
                         i, a_valid2, a2, a_last2, e[1], e[0]);
            end
            hist = {hist[1:0], a2};
            nbits++;
            if (nbits >= 3 && hist == 3'b101) y_count++;
            @(posedge clk); #1;
        end
        checks++;
        if (a_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL lsb_end got a_valid=%0b, expected 0", a_valid2);
        end
        checks++;
        if (y_count != 1) begin
            errors++;
            $display("FAIL detector_pulses got %0d, expected 1", y_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_lsb_detector();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
